cacheline_adaptor: RTL and testbench

//   Memory-side responder behind the cache arbiter. Accepts one full-line read or write request

---
 rtl/cacheline_adaptor.sv | 149 ++++++++++++++
 tb/tb_cacheline_adaptor.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adaptor.sv
// Cache-line adaptor: turns one full-line read/write request into a burst of
// BURST_W-wide beats on the physical-memory port and returns a one-cycle response.
module cacheline_adaptor #(
    parameter int unsigned LINE_W  = 256,
    parameter int unsigned BURST_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               read_i,
    input  logic               write_i,
    input  logic [31:0]        address_i,
    input  logic [LINE_W-1:0]  line_i,
    output logic               resp_o,
    output logic [LINE_W-1:0]  line_o,
    output logic               pmem_read,
    output logic               pmem_write,
    output logic [31:0]        pmem_address,
    output logic [BURST_W-1:0] pmem_wdata,
    input  logic [BURST_W-1:0] pmem_rdata,
    input  logic               pmem_resp
);

    localparam int unsigned BEATS = LINE_W / BURST_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFF_W = $clog2(LINE_W / 8);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [31:0]        addr_q, addr_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [LINE_W-1:0]  line_buf_q, line_buf_d;
    logic [BURST_W-1:0] wdata_q, wdata_d;
    logic               resp_q, resp_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic               last_beat;

    // Byte offset within the line never reaches memory; bursts are line aligned.
    logic unused_offset;
    assign unused_offset = ^address_i[OFF_W-1:0];

    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

    // Next-state and next-output computation for the burst sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        line_d     = line_q;
        line_buf_d = line_buf_q;
        wdata_d    = wdata_q;
        resp_d     = 1'b0;
        rd_d       = rd_q;
        wr_d       = wr_q;

        unique case (state_q)
            IDLE: begin
                // Write has priority so a dirty victim is written back before the refill.
                if (write_i) begin
                    addr_d  = {address_i[31:OFF_W], OFF_W'(0)};
                    line_d  = line_i;
                    wdata_d = line_i[BURST_W-1:0];
                    cnt_d   = '0;
                    wr_d    = 1'b1;
                    state_d = WR_BURST;
                end else if (read_i) begin
                    addr_d  = {address_i[31:OFF_W], OFF_W'(0)};
                    cnt_d   = '0;
                    rd_d    = 1'b1;
                    state_d = RD_BURST;
                end
            end
            RD_BURST: begin
                if (pmem_resp) begin
                    line_buf_d[BURST_W*cnt_q +: BURST_W] = pmem_rdata;
                    if (last_beat) begin
                        cnt_d   = '0;
                        rd_d    = 1'b0;
                        resp_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            WR_BURST: begin
                if (pmem_resp) begin
                    if (last_beat) begin
                        cnt_d   = '0;
                        wr_d    = 1'b0;
                        resp_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_inc;
                        wdata_d = line_q[BURST_W*cnt_inc +: BURST_W];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any burst immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            line_q     <= '0;
            line_buf_q <= '0;
            wdata_q    <= '0;
            resp_q     <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            line_q     <= line_d;
            line_buf_q <= line_buf_d;
            wdata_q    <= wdata_d;
            resp_q     <= resp_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
        end
    end

    assign resp_o       = resp_q;
    assign line_o       = line_buf_q;
    assign pmem_read    = rd_q;
    assign pmem_write   = wr_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Bench for cacheline_adaptor: a line-level model plus a beat-level memory responder.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic         read_i, write_i;
    logic [31:0]  address_i;
    logic [255:0] line_i;
    logic         resp_o;
    logic [255:0] line_o;
    logic         pmem_read, pmem_write;
    logic [31:0]  pmem_address;
    logic [63:0]  pmem_wdata, pmem_rdata;
    logic         pmem_resp;

    int checks   = 0;
    int failures = 0;
    logic [255:0] exp_line_o;

    always #5 clk = ~clk;

    cacheline_adaptor dut (
        .clk          (clk),
        .rst          (rst),
        .read_i       (read_i),
        .write_i      (write_i),
        .address_i    (address_i),
        .line_i       (line_i),
        .resp_o       (resp_o),
        .line_o       (line_o),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One transaction from the arbiter's side. Called at a negedge while the DUT is idle.
    // Every cycle: check burst kind/address/write beat against the line-level model, and play
    // memory (wt wait cycles before each ack). abort_at>0 fires async reset after that many beats.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [255:0] wline,
                           input logic [63:0] b0, input logic [63:0] b1,
                           input logic [63:0] b2, input logic [63:0] b3,
                           input int wt, input int abort_at,
                           output int lat, output logic [31:0] seen_addr,
                           output logic [255:0] seen_w);
        logic [63:0]  rb [4];
        logic [255:0] asm_line;
        logic [31:0]  exp_addr;
        logic         exp_wr;
        int           beat;
        int           wcnt;
        bit           done;
        rb        = '{b0, b1, b2, b3};
        asm_line  = {b3, b2, b1, b0};
        exp_addr  = {addr[31:5], 5'b0};
        exp_wr    = wr;
        beat      = 0;
        wcnt      = 0;
        done      = 1'b0;
        lat       = -1;
        seen_addr = '0;
        seen_w    = '0;
        read_i    = rd;
        write_i   = wr;
        address_i = addr;
        line_i    = wline;
        for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
            @(negedge clk);
            if (abort_at > 0 && beat == abort_at) begin
                pmem_resp = 1'b0;
                rst = 1'b1;
                #1;
                chk("rst_pmem_read_drop", 256'(pmem_read), 256'(0));
                chk("rst_no_resp", 256'(resp_o), 256'(0));
                chk("rst_line_o_cleared", line_o, '0);
                exp_line_o = '0;
                read_i  = 1'b0;
                write_i = 1'b0;
                #1 rst = 1'b0;
                lat  = 0;
                done = 1'b1;
            end else if (resp_o) begin
                pmem_resp = 1'b0;
                lat  = cyc;
                done = 1'b1;
                chk("beats_before_resp", 256'(beat), 256'(4));
                chk("pmem_idle_at_resp", 256'({pmem_read, pmem_write}), 256'(0));
                if (!exp_wr) exp_line_o = asm_line;
                chk("line_o_at_resp", line_o, exp_line_o);
                read_i  = 1'b0;
                write_i = 1'b0;
                @(negedge clk);
                chk("resp_single_cycle", 256'(resp_o), 256'(0));
            end else begin
                chk("burst_kind", 256'({pmem_read, pmem_write}),
                    exp_wr ? 256'(2'b01) : 256'(2'b10));
                chk("burst_address", 256'(pmem_address), 256'(exp_addr));
                seen_addr = pmem_address;
                if (exp_wr && beat < 4)
                    chk("write_beat_data", 256'(pmem_wdata), 256'(wline[64*beat +: 64]));
                if (beat < 4 && wcnt == wt) begin
                    if (exp_wr) seen_w[64*beat +: 64] = pmem_wdata;
                    pmem_resp  = 1'b1;
                    pmem_rdata = rb[beat];
                    beat++;
                    wcnt = 0;
                end else begin
                    pmem_resp  = 1'b0;
                    pmem_rdata = {$urandom, $urandom};
                    wcnt++;
                end
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL txn_timeout: got no resp_o after 300 cycles, expected one");
        end
        pmem_resp = 1'b0;
        read_i    = 1'b0;
        write_i   = 1'b0;
    endtask

    localparam logic [63:0] A = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] B = 64'hBBBB_BBBB_BBBB_BBBB;
    localparam logic [63:0] C = 64'hCCCC_CCCC_CCCC_CCCC;
    localparam logic [63:0] D = 64'hDDDD_DDDD_DDDD_DDDD;

    initial begin
        int           lat;
        logic [31:0]  sa;
        logic [255:0] sw;
        logic [255:0] held;

        rst        = 1'b1;
        read_i     = 1'b0;
        write_i    = 1'b0;
        address_i  = '0;
        line_i     = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;
        exp_line_o = '0;
        repeat (2) @(negedge clk);
        chk("reset_resp_o", 256'(resp_o), 256'(0));
        chk("reset_pmem_rw", 256'({pmem_read, pmem_write}), 256'(0));
        chk("reset_pmem_address", 256'(pmem_address), 256'(0));
        chk("reset_pmem_wdata", 256'(pmem_wdata), 256'(0));
        chk("reset_line_o", line_o, '0);
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait read: resp_o in the 6th cycle counting the request cycle.
        run_txn(1'b1, 1'b0, 32'h0000_1234, '0,
                64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 0, 0, lat, sa, sw);
        chk("t1_latency", 256'(lat), 256'(5));
        chk("t1_address", 256'(sa), 256'(32'h0000_1220));
        chk("t1_line", line_o, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

        // Write with two wait cycles per beat; line_o must not move.
        held = line_o;
        run_txn(1'b0, 1'b1, 32'h8000_00FF, {D, C, B, A}, '0, '0, '0, '0, 2, 0, lat, sa, sw);
        chk("t2_latency", 256'(lat), 256'(13));
        chk("t2_address", 256'(sa), 256'(32'h8000_00E0));
        chk("t2_wdata_order", sw, {D, C, B, A});
        chk("t2_line_o_held", line_o, held);

        // Read and write together: write burst only (burst_kind checks no read appears).
        run_txn(1'b1, 1'b1, 32'h0000_0047, {A, B, C, D}, '1, '1, '1, '1, 1, 0, lat, sa, sw);
        chk("t3_address", 256'(sa), 256'(32'h0000_0040));
        chk("t3_wdata_order", sw, {A, B, C, D});
        chk("t3_line_o_held", line_o, held);

        // Reset after two beats of a read, then a clean read.
        run_txn(1'b1, 1'b0, 32'h0000_3000, '0, A, B, C, D, 0, 2, lat, sa, sw);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_no_resp_after_abort", 256'({resp_o, pmem_read, pmem_write}), 256'(0));
        end
        run_txn(1'b1, 1'b0, 32'h0000_2010, '0,
                64'h0123_4567_89AB_CDEF, 64'h1, 64'h2, 64'hFEDC_BA98_7654_3210,
                0, 0, lat, sa, sw);
        chk("t4_fresh_line", line_o, {64'hFEDC_BA98_7654_3210, 64'h2, 64'h1,
                                      64'h0123_4567_89AB_CDEF});
        chk("t4_address", 256'(sa), 256'(32'h0000_2000));

        // Stray memory acks while idle are ignored.
        held = line_o;
        pmem_resp  = 1'b1;
        pmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t5_stray_ack_idle", 256'({resp_o, pmem_read, pmem_write}), 256'(0));
        end
        pmem_resp = 1'b0;
        @(negedge clk);
        chk("t5_stray_line_o", line_o, held);

        // Back-to-back write then read, one wait cycle per beat.
        run_txn(1'b0, 1'b1, 32'h0000_4444, {B, A, D, C}, '0, '0, '0, '0, 1, 0, lat, sa, sw);
        chk("t5_write_line_o_held", line_o, held);
        chk("t5_write_latency", 256'(lat), 256'(9));
        run_txn(1'b1, 1'b0, 32'h0000_5555, '0, D, C, B, A, 1, 0, lat, sa, sw);
        chk("t5_read_line", line_o, {A, B, C, D});
        chk("t5_read_address", 256'(sa), 256'(32'h0000_5540));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
